// File: rtl/inequality_pkg.sv
// Shared definitions for the Inequality evaluator arbiter: state encoding and
// default operand/result widths of the shared evaluator.
package inequality_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int NUM_W = 4;
   localparam int OUT_W = 3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      EVAL = ST_EVAL,
      RESP = ST_RESP
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin grant; prio picks the winner only when
// both requesters are valid.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       prio,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/inequality_arbiter.sv
// Time-shares one external combinational Inequality evaluator between two
// requesters; results come back on a tagged response channel.
module inequality_arbiter #(
   parameter int NUM_W = inequality_pkg::NUM_W,
   parameter int OUT_W = inequality_pkg::OUT_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [NUM_W-1:0] req0_num,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [NUM_W-1:0] req1_num,
   output logic             req1_ready,
   output logic [NUM_W-1:0] eval_num,
   input  logic [OUT_W-1:0] eval_out,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [OUT_W-1:0] rsp_out,
   input  logic             rsp_ready,
   output logic [CNT_W-1:0] served0,
   output logic [CNT_W-1:0] served1
);

   import inequality_pkg::*;

   state_e             state_q, state_d;
   logic               prio_q, prio_d;
   logic [NUM_W-1:0]   eval_num_q, eval_num_d;
   logic               rsp_id_q, rsp_id_d;
   logic [OUT_W-1:0]   rsp_out_q, rsp_out_d;
   logic [CNT_W-1:0]   served0_q, served0_d;
   logic [CNT_W-1:0]   served1_q, served1_d;
   logic [1:0]         grant;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   rr_arbiter2 u_rr (
      .valid  ({req1_valid, req0_valid}),
      .prio   (prio_q),
      .enable (state_q == IDLE),
      .grant  (grant)
   );

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      eval_num_d = eval_num_q;
      rsp_id_d   = rsp_id_q;
      rsp_out_d  = rsp_out_q;
      served0_d  = served0_q;
      served1_d  = served1_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               eval_num_d = grant[1] ? req1_num : req0_num;
               rsp_id_d   = grant[1];
               state_d    = EVAL;
            end
         end
         EVAL: begin
            rsp_out_d = eval_out;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               // Hand priority to the requester that was not just served.
               prio_d = ~rsp_id_q;
               if (rsp_id_q) served1_d = sat_inc(served1_q);
               else          served0_d = sat_inc(served0_q);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         eval_num_q <= '0;
         rsp_id_q   <= 1'b0;
         rsp_out_q  <= '0;
         served0_q  <= '0;
         served1_q  <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         eval_num_q <= eval_num_d;
         rsp_id_q   <= rsp_id_d;
         rsp_out_q  <= rsp_out_d;
         served0_q  <= served0_d;
         served1_q  <= served1_d;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign eval_num   = eval_num_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_out    = rsp_out_q;
   assign served0    = served0_q;
   assign served1    = served1_q;

endmodule

// File: tb/tb_inequality_arbiter.sv
// Directed bench for inequality_arbiter with a bench-side evaluator (reference
// Inequality model or a pass-through stub) closing the eval_num/eval_out loop.
module tb_inequality_arbiter;

   localparam int NUM_W = 4;
   localparam int OUT_W = 3;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic [NUM_W-1:0] req0_num, req1_num;
   logic             req0_ready, req1_ready;
   logic [NUM_W-1:0] eval_num;
   logic [OUT_W-1:0] eval_out;
   logic             rsp_valid;
   logic             rsp_id;
   logic [OUT_W-1:0] rsp_out;
   logic             rsp_ready;
   logic [CNT_W-1:0] served0, served1;

   logic             stub_mode;
   int               n_checks = 0;
   int               n_errors = 0;

   always #5 clk = ~clk;

   // Reference Inequality: bit0 NUM<5, bit1 NUM>5, bit2 NUM>10.
   function automatic logic [OUT_W-1:0] ineq_model(input logic [NUM_W-1:0] n);
      return {n > 4'd10, n > 4'd5, n < 4'd5};
   endfunction

   assign eval_out = stub_mode ? eval_num[2:0] : ineq_model(eval_num);

   inequality_arbiter #(.NUM_W(NUM_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_num   (req0_num),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_num   (req1_num),
      .req1_ready (req1_ready),
      .eval_num   (eval_num),
      .eval_out   (eval_out),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_out    (rsp_out),
      .rsp_ready  (rsp_ready),
      .served0    (served0),
      .served1    (served1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_num   = '0;   req1_num   = '0;
      rsp_ready  = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits (at negedges) for rsp_valid within a cycle budget.
   task automatic wait_rsp(input string tag, output logic id, output logic [OUT_W-1:0] out);
      bit found = 1'b0;
      id = 1'b0; out = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            found = 1'b1;
            id    = rsp_id;
            out   = rsp_out;
            break;
         end
      end
      check({tag, "_timeout"}, {31'd0, found}, 32'd1);
   endtask

   logic             got_id;
   logic [OUT_W-1:0] got_out;
   int               sat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      stub_mode = 1'b0;

      // Reset values
      do_reset();
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
      check("rst_rsp_out",   {29'd0, rsp_out},   32'd0);
      check("rst_eval_num",  {28'd0, eval_num},  32'd0);
      check("rst_served0",   {30'd0, served0},   32'd0);
      check("rst_served1",   {30'd0, served1},   32'd0);
      check("rst_ready",     {30'd0, req1_ready, req0_ready}, 32'd0);

      // Single request through the reference evaluator
      req0_valid = 1'b1; req0_num = 4'd3; rsp_ready = 1'b1;
      #1;
      check("t1_ready", {30'd0, req1_ready, req0_ready}, 32'b01);
      @(negedge clk);
      req0_valid = 1'b0;
      check("t1_eval_num",  {28'd0, eval_num},  32'd3);
      check("t1_eval_rspv", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("t1_rsp_id",    {31'd0, rsp_id},    32'd0);
      check("t1_rsp_out",   {29'd0, rsp_out},   32'b001);
      @(negedge clk);
      check("t1_served0",   {30'd0, served0},   32'd1);
      check("t1_done",      {31'd0, rsp_valid}, 32'd0);

      // Contention with the stub evaluator; valids held throughout
      stub_mode = 1'b1;
      do_reset();
      req0_valid = 1'b1; req0_num = 4'd5;
      req1_valid = 1'b1; req1_num = 4'd6;
      rsp_ready  = 1'b1;
      #1;
      check("t2_ready_a", {30'd0, req1_ready, req0_ready}, 32'b01);
      wait_rsp("t2_rsp_a", got_id, got_out);
      check("t2_id_a",  {31'd0, got_id},  32'd0);
      check("t2_out_a", {29'd0, got_out}, 32'b101);
      check("t2_busy_ready", {30'd0, req1_ready, req0_ready}, 32'b00);
      @(negedge clk);
      check("t2_ready_b", {30'd0, req1_ready, req0_ready}, 32'b10);
      wait_rsp("t2_rsp_b", got_id, got_out);
      check("t2_id_b",  {31'd0, got_id},  32'd1);
      check("t2_out_b", {29'd0, got_out}, 32'b110);
      @(negedge clk);
      check("t2_ready_c", {30'd0, req1_ready, req0_ready}, 32'b01);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure
      do_reset();
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_num = 4'd9;
      wait_rsp("t3_rsp", got_id, got_out);
      req0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("t3_hold_id",    {31'd0, rsp_id},    32'd1);
         check("t3_hold_out",   {29'd0, rsp_out},   32'b001);
         check("t3_hold_ready", {30'd0, req1_ready, req0_ready}, 32'b00);
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      check("t3_served1",  {30'd0, served1},   32'd1);
      check("t3_released", {31'd0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      check("t3_one_only", {30'd0, served1},   32'd1);

      // Reset while in EVAL
      do_reset();
      rsp_ready = 1'b1;
      req1_valid = 1'b1; req1_num = 4'd7;
      @(negedge clk);
      req1_valid = 1'b0;
      check("t4_in_eval", {28'd0, eval_num}, 32'd7);
      rst_n = 1'b0;
      #1;
      check("t4_rst_eval_num", {28'd0, eval_num},  32'd0);
      check("t4_rst_rsp_id",   {31'd0, rsp_id},    32'd0);
      check("t4_rst_rsp_v",    {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      check("t4_served1", {30'd0, served1}, 32'd0);
      req0_valid = 1'b1; req0_num = 4'd4;
      req1_valid = 1'b1; req1_num = 4'd2;
      wait_rsp("t4_rsp", got_id, got_out);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("t4_id",  {31'd0, got_id},  32'd0);
      check("t4_out", {29'd0, got_out}, 32'b100);

      // Served counter saturation
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req1_valid = 1'b1; req1_num = 4'(i + 1);
         wait_rsp("t5_rsp", got_id, got_out);
         req1_valid = 1'b0;
         @(negedge clk);
         check("t5_served1", {30'd0, served1}, sat_exp[i]);
         check("t5_served0", {30'd0, served0}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
